iter_divider: RTL and testbench

Iterative radix-2 restoring divider that serves the execute stage's DIV/DIVU requests. It returns a 32-bit quotient and remainder with a `complete` flag. The execute stage is the initiator: it holds `div` high while its operands are valid, and it aborts the operation by pulling `resetn` low whenever the pipeline flows. This block is the responder side of that request/complete handshake.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/iter_divider.sv | 122 ++++++++++++
 tb/tb_iter_divider.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef logic [1:0] div_state_t;

    localparam div_state_t IDLE = 2'd0;
    localparam div_state_t CALC = 2'd1;
    localparam div_state_t FIX  = 2'd2;
    localparam div_state_t DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, trial subtract.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH:0]   dsr,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_in, dvd_msb};
    assign trial   = shifted - dsr;

    // A clear sign bit means the divisor fits into the shifted remainder.
    assign q_bit   = ~trial[WIDTH];
    assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Optional DIV_ZERO_FAST_EN: a zero divisor completes one edge after load.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             complete
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0] dsr;
    logic sign_q;
    logic sign_r;

    logic neg_a;
    logic neg_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0] b_mag;
    logic [WIDTH-1:0] rem_nx;
    logic q_bit;
    logic zero_fast;

    assign neg_a = isSigned & A[WIDTH-1];
    assign neg_b = isSigned & B[WIDTH-1];

    // The quotient register carries the dividend; -2^(W-1) fits as unsigned.
    assign a_mag = neg_a ? -A : A;
    assign b_mag = neg_b ? -{1'b1, B} : {1'b0, B};

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (B == '0);
`else
    assign zero_fast = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_msb (quo[WIDTH-1]),
        .dsr     (dsr),
        .rem_out (rem_nx),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            Q        <= '0;
            R        <= '0;
            complete <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (div && zero_fast) begin
                        Q        <= '1;
                        R        <= A;
                        complete <= 1'b1;
                        state    <= DONE;
                    end else if (div) begin
                        sign_q <= isSigned & (A[WIDTH-1] ^ B[WIDTH-1]);
                        sign_r <= neg_a;
                        quo    <= a_mag;
                        dsr    <= b_mag;
                        rem    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (!div) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= {quo[WIDTH-2:0], q_bit};
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!div) begin
                        state <= IDLE;
                    end else begin
                        Q        <= sign_q ? -quo : quo;
                        R        <= sign_r ? -rem : rem;
                        complete <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (!div) begin
                        complete <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Randomized self-checking bench for iter_divider against a 64-bit model.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div = 1'b0;
    logic        isSigned = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Q;
    logic [31:0] R;
    logic        complete;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iter_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .div      (div),
        .isSigned (isSigned),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .complete (complete)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Truncating division on 64-bit integers; remainder follows dividend.
    function automatic void model(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic s,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa, sb, qq, rr;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        qq = sa / sb;
        rr = sa % sb;
        q = qq[31:0];
        r = rr[31:0];
    endfunction

    task automatic do_op(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic s,
                         input int hold,
                         input string tag);
        logic [31:0] eq, er;
        int lat, exp_lat;
        bit chk;
        chk = 1'b1;
        exp_lat = 33;
        eq = '0;
        er = '0;
        if (b != 0) begin
            model(a, b, s, eq, er);
        end else begin
`ifdef DIV_ZERO_FAST_EN
            eq = '1;
            er = a;
            exp_lat = 1;
`else
            chk = 1'b0;
`endif
        end
        A = a;
        B = b;
        isSigned = s;
        div = 1'b1;
        tick();
        A = $urandom;
        B = $urandom;
        isSigned = 1'($urandom);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!complete && lat < 40);
        check({tag, " latency"}, lat, exp_lat);
        if (chk) begin
            check({tag, " Q"}, Q, eq);
            check({tag, " R"}, R, er);
            for (int i = 0; i < hold; i++) begin
                tick();
                check({tag, " hold complete"}, complete, 1);
                check({tag, " hold Q"}, Q, eq);
                check({tag, " hold R"}, R, er);
            end
        end
        div = 1'b0;
        tick();
        check({tag, " drop complete"}, complete, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic rs;
        bit saw;

        repeat (3) tick();
        check("reset complete", complete, 0);
        check("reset Q", Q, 0);
        check("reset R", R, 0);
        resetn = 1'b1;
        tick();

        do_op(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div_m7_2");
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div_7_m2");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_ovf");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "divu_max_1");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0, "div_m1_1");
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "div_min_min");
        do_op(32'd12345, 32'd10, 1'b1, 5, "hold5");

        // Reset pulled at E+10 aborts the running operation.
        A = 32'd50;
        B = 32'd3;
        isSigned = 1'b0;
        div = 1'b1;
        tick();
        repeat (9) tick();
        resetn = 1'b0;
        tick();
        check("abort complete", complete, 0);
        check("abort Q", Q, 0);
        check("abort R", R, 0);
        resetn = 1'b1;
        div = 1'b0;
        tick();
        do_op(32'd9, 32'd3, 1'b0, 0, "after_reset");

        // Dropping div at E+5 returns to IDLE with no result.
        do_op(32'd1000, 32'd10, 1'b0, 0, "pre_drop");
        A = 32'd77;
        B = 32'd5;
        div = 1'b1;
        tick();
        repeat (4) tick();
        div = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (complete) saw = 1'b1;
        end
        check("drop no complete", saw, 0);
        check("drop Q kept", Q, 32'd100);
        check("drop R kept", R, 32'd0);
        do_op(32'd77, 32'd5, 1'b0, 0, "after_drop");

        do_op(32'h0000_1234, 32'd0, 1'b0, 0, "zero_divu");
        do_op(32'h8000_1234, 32'd0, 1'b1, 0, "zero_div");

        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if (rb == 0) rb = 32'd1;
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom);
            do_op(ra, rb, rs, $urandom_range(0, 2), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
